// File: rtl/feature_3_pkg.sv
// Shared definitions for the layer-3 serializer and the layer-4 input logic.
package feature_3_pkg;

    localparam int unsigned DATA_W    = 8;
    localparam int unsigned TOTAL_NUM = 36;
    localparam int unsigned BEAT_NUM  = 6;

    localparam int unsigned BEATS  = TOTAL_NUM / BEAT_NUM;
    localparam int unsigned BIDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

endpackage

// File: rtl/sync_fifo_wide.sv
// Wide synchronous FIFO; a push into a full FIFO is accepted when a pop occurs on the same edge.
module sync_fifo_wide #(
    parameter  int unsigned WIDTH = 8,
    parameter  int unsigned DEPTH = 2,
    localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CNT_W = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty,
    output logic [CNT_W-1:0] o_count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_wr;
    logic             w_rd;

    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_data  = r_mem[r_rd_ptr];

    assign w_rd = i_pop && !o_empty;
    assign w_wr = i_push && (!o_full || w_rd);

    // Pointer and occupancy bookkeeping; pointers wrap naturally at a power-of-two depth.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Word storage; contents are only observed through a non-empty head, so no reset.
    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

// File: rtl/feature_serialize_3.sv
// Layer-3 rescale output serializer: buffers 36-element words and replays them as 6-element beats.
// Optional macro FEATURE_SERIALIZE_3_RELU_EN clamps negative output elements to zero at the output mux.
module feature_serialize_3
    import feature_3_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [DATA_W*TOTAL_NUM-1:0]   data_i,
    input  logic                          valid_i,
    output logic [DATA_W*BEAT_NUM-1:0]    data_o,
    output logic                          valid_o,
    input  logic                          ready_i,
    output logic [BIDX_W-1:0]             beat_idx_o,
    output logic                          last_o,
    output logic                          overflow_o
);

    localparam int unsigned IN_W  = DATA_W * TOTAL_NUM;
    localparam int unsigned OUT_W = DATA_W * BEAT_NUM;
    localparam int unsigned CNT_W = ((FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1) + 1;

    state_e              r_state;
    state_e              w_state_nxt;
    logic [BIDX_W-1:0]   r_beat;
    logic [BIDX_W-1:0]   w_beat_nxt;
    logic                r_last;
    logic                w_last_nxt;
    logic                r_ovf;

    logic [IN_W-1:0]     w_head;
    logic                w_full;
    logic                w_empty;
    logic [CNT_W-1:0]    w_count;
    logic                w_hs;
    logic                w_at_last;
    logic                w_pop;
    logic                w_push;
    logic [OUT_W-1:0]    w_data;
    logic [DATA_W-1:0]   w_elem;

    assign w_hs      = (r_state == SEND) && !w_empty && ready_i;
    assign w_at_last = (r_beat == BIDX_W'(BEATS - 1));
    assign w_pop     = w_hs && w_at_last;
    assign w_push    = valid_i && (!w_full || w_pop);

    sync_fifo_wide #(
        .WIDTH (IN_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (data_i),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // State, beat counter and last-beat flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_beat  <= '0;
            r_last  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_beat  <= w_beat_nxt;
            r_last  <= w_last_nxt;
        end
    end

    // Next-state: advance one beat per handshake, pop the head on the final beat.
    always_comb begin
        w_state_nxt = r_state;
        w_beat_nxt  = r_beat;
        case (r_state)
            IDLE: begin
                if (w_push) w_state_nxt = SEND;
            end
            SEND: begin
                if (w_hs) begin
                    if (w_at_last) begin
                        w_beat_nxt = '0;
                        if ((w_count == CNT_W'(1)) && !w_push) w_state_nxt = IDLE;
                    end else begin
                        w_beat_nxt = r_beat + BIDX_W'(1);
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
        w_last_nxt = (w_state_nxt == SEND) && (w_beat_nxt == BIDX_W'(BEATS - 1));
    end

    // Sticky flag for an input word that arrived with no free slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if (valid_i && !w_push) begin
            r_ovf <= 1'b1;
        end
    end

    // Select the current beat from the FIFO head; zero while nothing is presented.
    always_comb begin
        w_data = '0;
        w_elem = '0;
        if (r_state == SEND) begin
            for (int j = 0; j < int'(BEAT_NUM); j++) begin
                w_elem = w_head[(int'(r_beat) * int'(BEAT_NUM) + j) * int'(DATA_W) +: DATA_W];
`ifdef FEATURE_SERIALIZE_3_RELU_EN
                if (w_elem[DATA_W-1]) w_elem = '0;
`else
                w_elem = w_elem;
`endif
                w_data[j * int'(DATA_W) +: DATA_W] = w_elem;
            end
        end
    end

    assign data_o     = w_data;
    assign valid_o    = (r_state == SEND);
    assign beat_idx_o = r_beat;
    assign last_o     = r_last;
    assign overflow_o = r_ovf;

endmodule

// File: tb/tb_feature_serialize_3.sv
// Self-checking bench for feature_serialize_3: vector table, corner sequences, random vs queue model.
module tb_feature_serialize_3;
    import feature_3_pkg::*;

    localparam int unsigned IN_W       = DATA_W * TOTAL_NUM;
    localparam int unsigned OUT_W      = DATA_W * BEAT_NUM;
    localparam int unsigned FIFO_DEPTH = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [IN_W-1:0]   data_i;
    logic              valid_i;
    logic [OUT_W-1:0]  data_o;
    logic              valid_o;
    logic              ready_i;
    logic [BIDX_W-1:0] beat_idx_o;
    logic              last_o;
    logic              overflow_o;

    feature_serialize_3 #(.FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .data_i     (data_i),
        .valid_i    (valid_i),
        .data_o     (data_o),
        .valid_o    (valid_o),
        .ready_i    (ready_i),
        .beat_idx_o (beat_idx_o),
        .last_o     (last_o),
        .overflow_o (overflow_o)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: a queue of whole words, the index of the beat on offer, a sticky drop flag.
    logic [IN_W-1:0] m_q[$];
    int              m_beat;
    bit              m_ovf;

    typedef struct {
        bit vi;
        bit rdy;
        bit ev;
        int eidx;
        bit elast;
        int ee0;
    } vec_t;

    vec_t vec[10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [IN_W-1:0] ramp_word();
        logic [IN_W-1:0] w;
        w = '0;
        for (int k = 0; k < int'(TOTAL_NUM); k++) w[k*DATA_W +: DATA_W] = DATA_W'(k);
        return w;
    endfunction

    function automatic logic [OUT_W-1:0] ramp_beat(input int e0);
        logic [OUT_W-1:0] r;
        r = '0;
        for (int j = 0; j < int'(BEAT_NUM); j++) r[j*DATA_W +: DATA_W] = DATA_W'(e0 + j);
        return r;
    endfunction

    function automatic logic [IN_W-1:0] rand_word();
        logic [IN_W-1:0] w;
        w = '0;
        for (int i = 0; i < int'(IN_W / 32); i++) w[i*32 +: 32] = $urandom();
        return w;
    endfunction

    function automatic logic [DATA_W-1:0] relu(input logic [DATA_W-1:0] e);
`ifdef FEATURE_SERIALIZE_3_RELU_EN
        return e[DATA_W-1] ? '0 : e;
`else
        return e;
`endif
    endfunction

    function automatic logic [OUT_W-1:0] model_data();
        logic [OUT_W-1:0] r;
        logic [IN_W-1:0]  head;
        r = '0;
        if (m_q.size() > 0) begin
            head = m_q[0];
            for (int j = 0; j < int'(BEAT_NUM); j++)
                r[j*DATA_W +: DATA_W] = relu(head[(m_beat*int'(BEAT_NUM) + j)*int'(DATA_W) +: DATA_W]);
        end
        return r;
    endfunction

    task automatic model_edge(input bit vi, input logic [IN_W-1:0] d, input bit rdy);
        if (m_q.size() > 0 && rdy) begin
            if (m_beat == int'(BEATS) - 1) begin
                m_q.delete(0);
                m_beat = 0;
            end else begin
                m_beat++;
            end
        end
        if (vi) begin
            if (m_q.size() < int'(FIFO_DEPTH)) m_q.push_back(d);
            else m_ovf = 1'b1;
        end
    endtask

    task automatic model_clear();
        m_q.delete();
        m_beat = 0;
        m_ovf  = 1'b0;
    endtask

    task automatic compare_model();
        bit ev;
        ev = (m_q.size() > 0);
        chk("valid_o", 64'(valid_o), 64'(ev));
        chk("data_o", 64'(data_o), 64'(model_data()));
        chk("beat_idx_o", 64'(beat_idx_o), ev ? 64'(m_beat) : 64'd0);
        chk("last_o", 64'(last_o), 64'(ev && (m_beat == int'(BEATS) - 1)));
        chk("overflow_o", 64'(overflow_o), 64'(m_ovf));
    endtask

    // One clock: drive inputs, clock, update model, check outputs just after the edge.
    task automatic cycle(input bit vi, input logic [IN_W-1:0] d, input bit rdy);
        valid_i = vi;
        data_i  = d;
        ready_i = rdy;
        @(posedge clk);
        model_edge(vi, d, rdy);
        #1;
        valid_i = 1'b0;
        compare_model();
    endtask

    task automatic do_reset();
        valid_i = 1'b0;
        ready_i = 1'b0;
        data_i  = '0;
        rst_n   = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_clear();
    endtask

    initial begin
        int  hs_cnt;
        int  valid_cnt;
        int  first_idle;
        logic [IN_W-1:0] w;

        // Single ramp word, ready high except three cycles of stall on beat 2.
        vec[0] = '{1, 1, 1, 0, 0, 0};
        vec[1] = '{0, 1, 1, 1, 0, 6};
        vec[2] = '{0, 1, 1, 2, 0, 12};
        vec[3] = '{0, 0, 1, 2, 0, 12};
        vec[4] = '{0, 0, 1, 2, 0, 12};
        vec[5] = '{0, 0, 1, 2, 0, 12};
        vec[6] = '{0, 1, 1, 3, 0, 18};
        vec[7] = '{0, 1, 1, 4, 0, 24};
        vec[8] = '{0, 1, 1, 5, 1, 30};
        vec[9] = '{0, 1, 0, 0, 0, 0};

        rst_n   = 1'b0;
        valid_i = 1'b0;
        ready_i = 1'b0;
        data_i  = '0;
        model_clear();
        #1;
        chk("reset valid_o", 64'(valid_o), 64'd0);
        chk("reset data_o", 64'(data_o), 64'd0);
        chk("reset beat_idx_o", 64'(beat_idx_o), 64'd0);
        chk("reset last_o", 64'(last_o), 64'd0);
        chk("reset overflow_o", 64'(overflow_o), 64'd0);
        do_reset();

        for (int i = 0; i < 10; i++) begin
            cycle(vec[i].vi, ramp_word(), vec[i].rdy);
            chk($sformatf("vec%0d valid", i), 64'(valid_o), 64'(vec[i].ev));
            chk($sformatf("vec%0d idx", i), 64'(beat_idx_o), 64'(vec[i].eidx));
            chk($sformatf("vec%0d last", i), 64'(last_o), 64'(vec[i].elast));
            chk($sformatf("vec%0d data", i), 64'(data_o),
                vec[i].ev ? 64'(ramp_beat(vec[i].ee0)) : 64'd0);
        end

        // Sign-bit elements: clamped only when the RELU option is built in.
        do_reset();
        w = ramp_word();
        w[7:0]   = 8'h80;
        w[15:8]  = 8'h7f;
        w[23:16] = 8'hff;
        cycle(1'b1, w, 1'b0);
`ifdef FEATURE_SERIALIZE_3_RELU_EN
        chk("relu elem0", 64'(data_o[7:0]), 64'h00);
        chk("relu elem2", 64'(data_o[23:16]), 64'h00);
`else
        chk("pass elem0", 64'(data_o[7:0]), 64'h80);
        chk("pass elem2", 64'(data_o[23:16]), 64'hff);
`endif
        chk("elem1 positive", 64'(data_o[15:8]), 64'h7f);
        for (int i = 0; i < int'(BEATS); i++) cycle(1'b0, '0, 1'b1);

        // Writes landing on the final-beat pop of a full FIFO are not dropped.
        do_reset();
        valid_cnt  = 0;
        first_idle = -1;
        for (int s = 0; s < 36; s++) begin
            cycle((s == 0) || (s == 1) || (s == 6) || (s == 12) || (s == 18), rand_word(), 1'b1);
            if (valid_o) valid_cnt++;
            else if (first_idle < 0) first_idle = s;
        end
        chk("fullpop valid beats", 64'(valid_cnt), 64'd30);
        chk("fullpop first idle", 64'(first_idle), 64'd30);
        chk("fullpop no overflow", 64'(overflow_o), 64'd0);

        // Three back-to-back words with no ready: third dropped, exactly 12 beats follow.
        do_reset();
        cycle(1'b1, rand_word(), 1'b0);
        cycle(1'b1, rand_word(), 1'b0);
        cycle(1'b1, rand_word(), 1'b0);
        chk("burst overflow set", 64'(overflow_o), 64'd1);
        hs_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (valid_o) hs_cnt++;
            cycle(1'b0, '0, 1'b1);
        end
        chk("burst beat count", 64'(hs_cnt), 64'd12);
        chk("burst overflow sticky", 64'(overflow_o), 64'd1);

        // Random traffic against the queue model.
        do_reset();
        for (int i = 0; i < 600; i++)
            cycle(($urandom_range(0, 6) == 0), rand_word(), ($urandom_range(0, 3) != 0));

        // Asynchronous reset during beat 3, then silence until a new word.
        do_reset();
        cycle(1'b1, ramp_word(), 1'b1);
        for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1);
        chk("pre-reset beat", 64'(beat_idx_o), 64'd3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async rst valid_o", 64'(valid_o), 64'd0);
        chk("async rst data_o", 64'(data_o), 64'd0);
        chk("async rst beat_idx_o", 64'(beat_idx_o), 64'd0);
        chk("async rst last_o", 64'(last_o), 64'd0);
        chk("async rst overflow_o", 64'(overflow_o), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_clear();
        for (int i = 0; i < 8; i++) cycle(1'b0, '0, 1'b1);
        chk("post-reset idle", 64'(valid_o), 64'd0);
        cycle(1'b1, ramp_word(), 1'b1);
        chk("post-reset restart", 64'(data_o), 64'(ramp_beat(0)));
        for (int i = 0; i < int'(BEATS); i++) cycle(1'b0, '0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/feature_serialize_3.md
# feature_serialize_3

Receiving end of the 3rd-layer rescale output. Captures the 36-element, 8-bit-per-element word that the rescale stage presents for one cycle with a valid pulse. Buffers it in a small FIFO and replays it to the 4th-layer input as a sequence of narrower beats under a valid/ready handshake. Absorbs the burst-vs-backpressure mismatch: the rescale side has no ready signal, the consumer side does.

## Interface
- DATA_W, 8, element width (signed int8 from rescale)
- TOTAL_NUM, 36, elements per input word
- BEAT_NUM, 6, elements per output beat; TOTAL_NUM must be a multiple of BEAT_NUM
- FIFO_DEPTH, 2, buffered input words (power of two, ≥2)

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- data_i  input  DATA_W*TOTAL_NUM  rescaled word; element k at bits [DATA_W*(k+1)-1 -: DATA_W]
- valid_i  input  1  single-cycle qualifier for data_i; no backpressure possible
- data_o  output  DATA_W*BEAT_NUM  current beat; beat element j = word element b*BEAT_NUM+j
- valid_o  output  1  beat valid
- ready_i  input  1  consumer accepts beat when valid_o && ready_i
- beat_idx_o  output  clog2(TOTAL_NUM/BEAT_NUM)  index b of the current beat
- last_o  output  1  high while the final beat (b = BEATS-1) is presented
- overflow_o  output  1  sticky: an input word was dropped

## Operation
- BEATS = TOTAL_NUM/BEAT_NUM (6 at defaults).
- Write: valid_i sampled high → word pushed into FIFO if not full after this edge's pop. A simultaneous pop of the last beat frees the slot in the same edge, so a write into a full FIFO is accepted when the head completes on that edge.
- Dropped write (full, no pop): word discarded, FIFO unchanged, overflow_o set; cleared only by rst_n.
- States: IDLE (FIFO empty, valid_o=0), SEND (FIFO non-empty, valid_o=1).
  - IDLE→SEND on any accepted write.
  - SEND: on handshake, beat counter increments. On handshake with b = BEATS-1, the head is popped and the counter returns to 0; the state stays SEND if another word remains or is written the same edge, else IDLE.
- data_o = slice b of FIFO head, muxed from registered storage. It is stable while valid_o && !ready_i.
- ready_i is ignored while valid_o=0. The beat counter never advances without a handshake.

## Timing
- Reset values: valid_o=0, data_o=0, beat_idx_o=0, last_o=0, overflow_o=0; FIFO empty, counter 0, state IDLE.
- Latency: valid_i high at edge N into an empty FIFO → valid_o=1 with beat 0 during cycle N+1.
- Throughput: one beat per cycle with ready_i held high; one word per BEATS cycles. The input must average ≤1 word per BEATS cycles. Bursts up to FIFO_DEPTH words are absorbed.
- Reset asserted mid-word: all state is discarded immediately; no partial beat resumes after release.
- last_o and beat_idx_o are valid only while valid_o=1; they are 0 otherwise.

## Configuration
- FEATURE_SERIALIZE_3_RELU_EN defined: each output element is clamped to 0 when negative (sign bit set), applied at the data_o mux. Stored words are unmodified.
- Undefined: data_o passes elements through unchanged.
- Handshake and timing are identical in both cases.

## Structure
- Package feature_3_pkg holds:
  - DATA_W, TOTAL_NUM, BEAT_NUM defaults
  - derived BEATS and beat-index width
  - the IDLE/SEND state enum, shared with the 4th-layer input logic
- One sub-module, sync_fifo_wide: parameterised width/depth, push/pop/full/empty, same-edge push+pop when full. The top holds the FSM, beat counter, output mux, RELU option and overflow flag.

## Test plan
- Single word, elements k=0..35 valued k, ready_i=1:
  - valid_o high from cycle N+1 for 6 cycles.
  - Beat 0 = {5,4,3,2,1,0} (MSB..LSB); last_o only on beat 5 = {35..30}.
  - Then IDLE.
- Same word, ready_i low on beat 2 for 3 cycles: data_o holds {17..12} and beat_idx_o=2 throughout; the sequence then completes normally.
- Three words on consecutive cycles, ready_i=0:
  - First two stored; third dropped; overflow_o=1 and stays 1.
  - After ready_i=1: exactly 12 beats.
- Words every 6 cycles with ready_i=1, the write coinciding with the last-beat pop while full: no drop, overflow_o=0, continuous valid_o.
- Element value 0x80 with RELU_EN defined → data_o element 0x00. Without it → 0x80.
- rst_n low during beat 3: all outputs 0 asynchronously. After release, valid_o stays 0 until a new valid_i arrives.
